// File: rtl/button_debounce_multi.sv
// N-channel button conditioner: 2-flop synchroniser, retrigger-hold or
// stable-integrate debounce, press/release pulses and a long-press flag.
module button_debounce_multi #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned HOLD       = 15,
  parameter int unsigned MODE       = 0,
  parameter int unsigned LONG_W     = 6,
  parameter int unsigned LONG_TICKS = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_en,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press,
  output logic            any_pressed
);

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] prev;

  // Synchroniser runs every clk, independent of the tick pacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= btn_raw;
      s     <= sync1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    if (MODE == 0) begin : g_hold
      localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
      logic [CNT_W-1:0] cnt;

      // A live input reloads the hold window and beats a concurrent tick.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt <= '0;
        else if (s[i])
          cnt <= HOLD_C;
        else if (tick_en && (cnt != '0))
          cnt <= cnt - 1'b1;
      end

      assign btn_out[i] = (cnt != '0);
    end else begin : g_integ
      localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
      logic [CNT_W-1:0] cnt;
      logic             st;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
          st  <= 1'b0;
        end else if (s[i] == st) begin
          cnt <= '0;
        end else if (tick_en) begin
          if (cnt == HOLD_M1) begin
            st  <= s[i];
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign btn_out[i] = st;
    end

    if (LONG_TICKS > 0) begin : g_long
      localparam logic [LONG_W-1:0] LONG_C = LONG_W'(LONG_TICKS);
      logic [LONG_W-1:0] lcnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          lcnt <= '0;
        else if (!btn_out[i])
          lcnt <= '0;
        else if (tick_en && (lcnt != LONG_C))
          lcnt <= lcnt + 1'b1;
      end

      // Gated by btn_out so the flag drops in the release cycle, before lcnt clears.
      assign long_press[i] = btn_out[i] && (lcnt == LONG_C);
    end else begin : g_no_long
      assign long_press[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prev <= '0;
    else
      prev <= btn_out;
  end

  assign press_pulse   = btn_out & ~prev;
  assign release_pulse = ~btn_out & prev;
  assign any_pressed   = |btn_out;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench: stimulus queues expected edge events with their cycle,
// a negedge monitor matches observed pulses/long-press edges against them.
module tb_button_debounce_multi;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LON   = 2;
  localparam int K_LOFF  = 3;

  typedef struct {
    int dut;
    int kind;
    int ch;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];
  logic [3:0] lprev [3];
  string kname [4] = '{"press", "release", "long_on", "long_off"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0 ticks on every 4th edge (edges where cyc becomes a multiple of 4).
  logic tick0;
  logic tick1 = 1'b1;
  logic tick2 = 1'b1;
  assign tick0 = ((cyc % 4) == 3);

  logic [1:0] raw0, bo0, pp0, rp0, lp0;
  logic [1:0] raw1, bo1, pp1, rp1, lp1;
  logic [3:0] raw2, bo2, pp2, rp2, lp2;
  logic       ap0, ap1, ap2;

  button_debounce_multi #(.N_CH(2), .CNT_W(4), .HOLD(15), .MODE(0),
                          .LONG_W(6), .LONG_TICKS(48)) u0 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick0), .btn_raw(raw0),
    .btn_out(bo0), .press_pulse(pp0), .release_pulse(rp0),
    .long_press(lp0), .any_pressed(ap0));

  button_debounce_multi #(.N_CH(2), .CNT_W(4), .HOLD(4), .MODE(1),
                          .LONG_W(6), .LONG_TICKS(48)) u1 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick1), .btn_raw(raw1),
    .btn_out(bo1), .press_pulse(pp1), .release_pulse(rp1),
    .long_press(lp1), .any_pressed(ap1));

  button_debounce_multi #(.N_CH(4), .CNT_W(4), .HOLD(3), .MODE(0),
                          .LONG_W(6), .LONG_TICKS(0)) u2 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick2), .btn_raw(raw2),
    .btn_out(bo2), .press_pulse(pp2), .release_pulse(rp2),
    .long_press(lp2), .any_pressed(ap2));

  task automatic expect_ev(input int d, input int k, input int ch, input int at);
    ev_t e;
    e.dut = d; e.kind = k; e.ch = ch; e.at = at;
    sb.push_back(e);
  endtask

  task automatic observe(input int d, input int k, input int ch);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].dut == d && sb[i].kind == k && sb[i].ch == ch && sb[i].at == cyc)
        idx = i;
    checks++;
    if (idx >= 0) begin
      sb.delete(idx);
    end else begin
      errors++;
      $display("FAIL event u%0d %s ch%0d: seen at cyc %0d, required none", d, kname[k], ch, cyc);
    end
  endtask

  task automatic scan(input int d, input logic [3:0] pp, input logic [3:0] rp, input logic [3:0] lp);
    for (int c = 0; c < 4; c++) begin
      if (pp[c]) observe(d, K_PRESS, c);
      if (rp[c]) observe(d, K_REL, c);
      if (lp[c] && !lprev[d][c]) observe(d, K_LON, c);
      if (!lp[c] && lprev[d][c]) observe(d, K_LOFF, c);
    end
    lprev[d] = lp;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) lprev[d] = '0;
  end

  always @(negedge clk) begin
    scan(0, {2'b00, pp0}, {2'b00, rp0}, {2'b00, lp0});
    scan(1, {2'b00, pp1}, {2'b00, rp1}, {2'b00, lp1});
    scan(2, pp2, rp2, lp2);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing u%0d %s ch%0d: seen none, required at cyc %0d",
                 sb[i].dut, kname[sb[i].kind], sb[i].ch, sb[i].at);
        sb.delete(i);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, required 'h%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_u0"}, 32'({bo0, pp0, rp0, lp0, ap0}), 32'd0);
    chk({tag, "_u1"}, 32'({bo1, pp1, rp1, lp1, ap1}), 32'd0);
    chk({tag, "_u2"}, 32'({bo2, pp2, rp2, lp2, ap2}), 32'd0);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Returns at a negedge where cyc % 4 == 1, so a press lands on a tick edge.
  task automatic align4();
    @(negedge clk);
    while ((cyc % 4) != 1) @(negedge clk);
  endtask

  initial begin
    int c, d, r, e, f, h, j;
    raw0 = '0; raw1 = '0; raw2 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("first_clk");

    // u0: one-clk press on ch0 -> high for exactly 15 ticks.
    align4();
    c = cyc;
    raw0 = 2'b01;
    expect_ev(0, K_PRESS, 0, c + 3);
    expect_ev(0, K_REL, 0, c + 63);
    @(negedge clk);
    raw0 = 2'b00;
    wait_until(c + 62);
    chk("u0_hold_last", 32'(bo0), 32'd1);
    wait_until(c + 70);

    // u0: re-press during countdown reloads the window without extra pulses.
    align4();
    c = cyc;
    raw0 = 2'b01;
    expect_ev(0, K_PRESS, 0, c + 3);
    expect_ev(0, K_REL, 0, c + 103);
    @(negedge clk);
    raw0 = 2'b00;
    wait_until(c + 40);
    raw0 = 2'b01;
    @(negedge clk);
    raw0 = 2'b00;
    wait_until(c + 110);

    // u0: long press on ch1.
    align4();
    d = cyc;
    raw0 = 2'b10;
    expect_ev(0, K_PRESS, 1, d + 3);
    expect_ev(0, K_LON, 1, d + 195);
    wait_until(d + 200);
    r = cyc;
    raw0 = 2'b00;
    chk("u0_long_held", 32'(lp0), 32'd2);
    expect_ev(0, K_REL, 1, r + 59);
    expect_ev(0, K_LOFF, 1, r + 59);
    wait_until(r + 70);

    // u0: both channels together, then reset mid-hold.
    align4();
    e = cyc;
    raw0 = 2'b11;
    expect_ev(0, K_PRESS, 0, e + 3);
    expect_ev(0, K_PRESS, 1, e + 3);
    wait_until(e + 2);
    chk("u0_any_before", 32'(ap0), 32'd0);
    wait_until(e + 3);
    chk("u0_any_after", 32'(ap0), 32'd1);
    chk("u0_both_out", 32'(bo0), 32'd3);
    wait_until(e + 10);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    raw0 = 2'b00;
    wait_until(e + 13);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_mid_reset");
    wait_until(e + 30);

    // u1 (integrate, HOLD=4): 2-clk toggling is rejected.
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      raw1 = (k % 2 == 0) ? 2'b11 : 2'b00;
      repeat (2) @(negedge clk);
    end
    chk("u1_glitch_rejected", 32'(bo1), 32'd0);
    f = cyc;
    raw1 = 2'b11;
    expect_ev(1, K_PRESS, 0, f + 6);
    expect_ev(1, K_PRESS, 1, f + 6);
    wait_until(f + 20);
    h = cyc;
    raw1 = 2'b00;
    expect_ev(1, K_REL, 0, h + 6);
    expect_ev(1, K_REL, 1, h + 6);
    wait_until(h + 15);

    // u2 (4 channels, HOLD=3, no long press): staggered independent events.
    @(negedge clk);
    j = cyc;
    raw2 = 4'b0001;
    expect_ev(2, K_PRESS, 0, j + 3);
    expect_ev(2, K_REL, 0, j + 6);
    @(negedge clk);
    raw2 = 4'b0100;
    expect_ev(2, K_PRESS, 2, j + 4);
    expect_ev(2, K_REL, 2, j + 7);
    @(negedge clk);
    raw2 = 4'b1000;
    expect_ev(2, K_PRESS, 3, j + 5);
    expect_ev(2, K_REL, 3, j + 10);
    wait_until(j + 5);
    raw2 = 4'b0000;
    chk("u2_levels", 32'(bo2), 32'hD);
    chk("u2_no_long", 32'(lp2), 32'd0);
    wait_until(j + 10);
    raw2 = 4'b0010;
    expect_ev(2, K_PRESS, 1, j + 13);
    expect_ev(2, K_REL, 1, j + 16);
    @(negedge clk);
    raw2 = 4'b0000;
    wait_until(j + 25);

    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL leftover u%0d %s ch%0d: seen none, required at cyc %0d",
               sb[0].dut, kname[sb[0].kind], sb[0].ch, sb[0].at);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
